metadata_packer: RTL and testbench
==================================

METADATA_PACKER -- requirements
Module: metadata_packer

Interface
REQ-001 Parameter DW, default 128: output beat width in bits.
REQ-002 Parameter IW, default 32: input word width in bits; DW SHALL be an integer multiple of IW, giving N = DW/IW lanes (default N = 4).
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 axis_in_tdata  input  IW  input metadata word.
REQ-006 axis_in_tvalid  input  1  input word valid.
REQ-007 axis_in_tlast  input  1  last word of a record; flushes a partial beat.
REQ-008 axis_in_tready  output  1  input word accepted when high together with tvalid.
REQ-009 axis_out_tdata  output  DW  packed beat, feeding the metadata splitter stage.
REQ-010 axis_out_tvalid  output  1  packed beat valid.
REQ-011 axis_out_tready  input  1  downstream ready.

Function
REQ-012 An input handshake (tvalid and tready high) SHALL write the word into lane cnt of the accumulator, bits [IW*cnt +: IW], with lane 0 in bits [IW-1:0], then increment cnt.
REQ-013 cnt SHALL be a $clog2(N)-bit counter, reset to 0, returning to 0 after lane N-1 is written or after a tlast word is accepted.
REQ-014 A beat SHALL complete on acceptance of lane N-1, or of any word with tlast high; on a tlast flush, lanes above the written lane SHALL be zero.
REQ-015 A tlast word in lane N-1 SHALL produce exactly one beat, not an extra empty beat.
REQ-016 After a beat completes, the accumulator SHALL clear to zero, so stale data never appears in padded lanes.
REQ-017 A completed beat SHALL appear on axis_out_tdata with axis_out_tvalid high in the cycle after the completing input handshake; latency is 1 cycle.
REQ-018 Output storage SHALL be a 2-entry skid buffer, with a main register driving the outputs and a skid register.
REQ-019 A completed beat SHALL load main if main is empty or is being consumed in that cycle; otherwise it SHALL load skid.
REQ-020 When main is consumed and skid is full, skid SHALL move to main in the same edge and skid SHALL empty.
REQ-021 axis_in_tready SHALL equal the registered value (not skid_valid) and SHALL have no combinational path from axis_out_tready.
REQ-022 Once axis_out_tvalid is high, axis_out_tdata SHALL remain stable until the output handshake occurs.
REQ-023 With axis_out_tready held high and one input word per cycle, the block SHALL sustain N input words per output beat with no bubbles.
REQ-024 Beats SHALL leave in the order completed; no beat SHALL be dropped or duplicated.
REQ-025 axis_in_tdata and axis_in_tlast SHALL be ignored when axis_in_tvalid is low.

Reset
REQ-026 While resetn is low, the following SHALL be 0: axis_out_tvalid, axis_out_tdata, axis_in_tready, cnt, the accumulator, and skid valid and skid data.
REQ-027 Reset asserted mid-beat SHALL discard the partial accumulator and any buffered beats; no beat SHALL emerge after release.
REQ-028 axis_in_tready SHALL rise on the first clock edge after resetn deasserts.

Structure
REQ-029 Shared package metadata_pkg SHALL hold the DW and IW defaults, the lane count N, and the counter width constant, so the splitter and packer agree.
REQ-030 The skid buffer SHALL be a sub-module, axis_skid_buffer, parameterized by DW; the packer top holds the counter and accumulator.

Verification
REQ-031 Words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with out_tready=1 -> one beat 0x44444444_33333333_22222222_11111111, one cycle after the 4th word.
REQ-032 Words 0xAAAA0001, 0xAAAA0002 with tlast on the second -> beat 0x00000000_00000000_AAAA0002_AAAA0001; the next record starts in lane 0.
REQ-033 Eight consecutive words with out_tready=0 -> two beats held, axis_in_tready falls after the second beat; raising out_tready releases both in order, and tready returns.
REQ-034 Sixteen words back-to-back with out_tready=1 -> four beats, with no in_tready deassertion.
REQ-035 Reset pulse after 2 of 4 words, then 4 fresh words 0x5..0x8 -> only beat 0x00000008_00000007_00000006_00000005 emerges.
REQ-036 Randomized tvalid/tready with a scoreboard over 1000 words -> every beat matches reference packing, and out_tdata is stable while stalled.

Source files
------------

// File: rtl/metadata_pkg.sv
// Shared constants for the metadata packer and splitter: beat/word widths and lane counter sizing.
package metadata_pkg;

  localparam int unsigned DwDefault = 128;
  localparam int unsigned IwDefault = 32;
  localparam int unsigned NumLanes  = DwDefault / IwDefault;

  // A single-lane configuration still needs a 1-bit counter to stay legal.
  function automatic int unsigned cnt_width(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  localparam int unsigned CntW = cnt_width(NumLanes);

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer: main register drives the outputs, skid absorbs one extra beat.
module axis_skid_buffer
  import metadata_pkg::*;
#(
  parameter int unsigned DW = DwDefault
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          main_valid_q, main_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          ready_q;
  logic          push, pop;

  assign push = in_valid & ready_q;
  assign pop  = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (pop) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_d       = '0;
        skid_valid_d = 1'b0;
      end else begin
        main_d       = '0;
        main_valid_d = 1'b0;
      end
    end
    // ready_q guarantees the skid slot is free whenever a push happens.
    if (push) begin
      if (!main_valid_d) begin
        main_d       = in_data;
        main_valid_d = 1'b1;
      end else begin
        skid_d       = in_data;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ~skid_valid_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_data  = main_q;
  assign out_valid = main_valid_q;

endmodule

// File: rtl/metadata_packer.sv
// Packs IW-bit metadata words into DW-bit beats, lane 0 in the low bits; tlast flushes a partial beat.
module metadata_packer
  import metadata_pkg::*;
#(
  parameter int unsigned DW = DwDefault,
  parameter int unsigned IW = IwDefault
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [IW-1:0] axis_in_tdata,
  input  logic          axis_in_tvalid,
  input  logic          axis_in_tlast,
  output logic          axis_in_tready,
  output logic [DW-1:0] axis_out_tdata,
  output logic          axis_out_tvalid,
  input  logic          axis_out_tready
);

  localparam int unsigned N    = DW / IW;
  localparam int unsigned CW   = cnt_width(N);
  localparam logic [CW-1:0] LastLane = CW'(N - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] merged;
  logic          in_hs;
  logic          beat_done;

  assign in_hs     = axis_in_tvalid & axis_in_tready;
  assign beat_done = in_hs & (axis_in_tlast | (cnt_q == LastLane));

  always_comb begin
    merged = acc_q;
    merged[IW*cnt_q +: IW] = axis_in_tdata;
  end

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (beat_done) begin
      // The accumulator clears so padded lanes of the next flush are zero.
      cnt_d = '0;
      acc_d = '0;
    end else if (in_hs) begin
      cnt_d = cnt_q + CW'(1);
      acc_d = merged;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  axis_skid_buffer #(
    .DW (DW)
  ) u_skid (
    .clk       (clk),
    .resetn    (resetn),
    .in_data   (merged),
    .in_valid  (beat_done),
    .in_ready  (axis_in_tready),
    .out_data  (axis_out_tdata),
    .out_valid (axis_out_tvalid),
    .out_ready (axis_out_tready)
  );

endmodule

// File: tb/tb_metadata_packer.sv
// Directed and randomized checks of metadata_packer against a reference packing scoreboard.
module tb_metadata_packer;

  localparam int unsigned DW = 128;
  localparam int unsigned IW = 32;
  localparam int unsigned N  = DW / IW;

  logic          clk = 1'b0;
  logic          resetn;
  logic [IW-1:0] in_tdata;
  logic          in_tvalid;
  logic          in_tlast;
  logic          in_tready;
  logic [DW-1:0] out_tdata;
  logic          out_tvalid;
  logic          out_tready;

  int vectors     = 0;
  int miscompares = 0;
  int pop_count   = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_acc;
  int unsigned   m_cnt;
  logic          prev_stall;
  logic [DW-1:0] prev_data;

  always #5 clk = ~clk;

  metadata_packer #(
    .DW (DW),
    .IW (IW)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .axis_in_tdata   (in_tdata),
    .axis_in_tvalid  (in_tvalid),
    .axis_in_tlast   (in_tlast),
    .axis_in_tready  (in_tready),
    .axis_out_tdata  (out_tdata),
    .axis_out_tvalid (out_tvalid),
    .axis_out_tready (out_tready)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model and scoreboard, sampled mid-cycle so handshakes are settled.
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
      m_acc      = '0;
      m_cnt      = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_stable", out_tdata, prev_data);
      if (out_tvalid && out_tready) begin
        pop_count++;
        if (exp_q.size() == 0) chk("unexpected_beat", out_tdata, 'x);
        else chk("beat", out_tdata, exp_q.pop_front());
      end
      if (in_tvalid && in_tready) begin
        m_acc[IW*m_cnt +: IW] = in_tdata;
        if (in_tlast || m_cnt == N - 1) begin
          exp_q.push_back(m_acc);
          m_acc = '0;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      prev_stall = out_tvalid && !out_tready;
      prev_data  = out_tdata;
    end
  end

  task automatic idle_inputs();
    in_tvalid = 1'b0;
    in_tdata  = 32'hDEAD_BEEF;
    in_tlast  = 1'b1;
  endtask

  // Present one word and hold it until accepted; returns the number of stalled cycles.
  task automatic send(input logic [IW-1:0] d, input logic l, output int waits);
    waits     = 0;
    in_tvalid = 1'b1;
    in_tdata  = d;
    in_tlast  = l;
    forever begin
      @(negedge clk);
      if (in_tready) break;
      waits++;
      if (waits > 200) begin
        chk("send_timeout", 128'(waits), 128'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    int w;
    int stalls;
    int base;
    int sent;
    int cyc;
    logic took;

    resetn     = 1'b0;
    out_tready = 1'b1;
    idle_inputs();
    #12;
    chk("rst_out_tvalid", 128'(out_tvalid), 128'd0);
    chk("rst_out_tdata", out_tdata, 128'd0);
    chk("rst_in_tready", 128'(in_tready), 128'd0);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_after_rst", 128'(in_tready), 128'd1);

    // Full beat, one-cycle latency.
    send(32'h1111_1111, 1'b0, w);
    send(32'h2222_2222, 1'b0, w);
    send(32'h3333_3333, 1'b0, w);
    send(32'h4444_4444, 1'b0, w);
    chk("full_valid", 128'(out_tvalid), 128'd1);
    chk("full_data", out_tdata, 128'h44444444_33333333_22222222_11111111);

    // tlast flush pads upper lanes with zero.
    send(32'hAAAA_0001, 1'b0, w);
    send(32'hAAAA_0002, 1'b1, w);
    chk("flush_data", out_tdata, 128'h00000000_00000000_AAAA0002_AAAA0001);

    // tlast on the final lane yields exactly one beat.
    repeat (2) @(posedge clk);
    #1;
    base = pop_count;
    for (int i = 0; i < 4; i++) send(32'hB000_0000 + 32'(i), (i == 3), w);
    repeat (3) @(posedge clk);
    #1;
    chk("last_lane_beats", 128'(pop_count - base), 128'd1);

    // Backpressure: two beats fill main and skid, then ready falls.
    out_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'hC000_0000 + 32'(i), 1'b0, w);
    chk("bp_in_tready", 128'(in_tready), 128'd0);
    chk("bp_hold_data", out_tdata, 128'hC0000003_C0000002_C0000001_C0000000);
    out_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("bp_tready_back", 128'(in_tready), 128'd1);

    // Sixteen words back to back: four beats, no stalls.
    base   = pop_count;
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      send(32'hD000_0000 + 32'(i), 1'b0, w);
      stalls += w;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_stalls", 128'(stalls), 128'd0);
    chk("b2b_beats", 128'(pop_count - base), 128'd4);

    // Reset mid-beat discards the partial accumulator.
    send(32'hEEEE_0001, 1'b0, w);
    send(32'hEEEE_0002, 1'b0, w);
    resetn = 1'b0;
    #3;
    chk("midrst_tvalid", 128'(out_tvalid), 128'd0);
    chk("midrst_tready", 128'(in_tready), 128'd0);
    @(negedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    base = pop_count;
    for (int i = 5; i <= 8; i++) send(32'(i), 1'b0, w);
    chk("post_rst_data", out_tdata, 128'h00000008_00000007_00000006_00000005);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_beats", 128'(pop_count - base), 128'd1);

    // Randomized valid/ready traffic.
    sent = 0;
    cyc  = 0;
    while (sent < 1000 && cyc < 20000) begin
      @(negedge clk);
      took = in_tvalid && in_tready;
      @(posedge clk);
      #1;
      cyc++;
      if (took) sent++;
      if (took || !in_tvalid) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin
          in_tvalid = 1'b1;
          in_tdata  = $urandom;
          in_tlast  = ($urandom_range(0, 7) == 0);
        end else begin
          idle_inputs();
        end
      end
      out_tready = ($urandom_range(0, 3) != 0);
    end
    chk("rand_words_sent", 128'(sent), 128'd1000);
    idle_inputs();
    out_tready = 1'b1;
    send(32'hF1F1_F1F1, 1'b1, w);
    repeat (6) @(posedge clk);
    #1;
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    chk("final_out_tvalid", 128'(out_tvalid), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
